// File: rtl/uart_rx.sv
// uart_rx: UART receiver driven by a sample_tick at OVERSAMPLE x the baud rate.
// Frame: start bit (0), DATA_BITS data bits LSB first, optional odd parity bit,
// one stop bit (1). Bit centres are recovered from the start-bit falling edge.
// Compile-time option UART_RX_MAJORITY_VOTE_EN: each bit is the 2-of-3
// majority of rx_s around the nominal sample tick, decided one tick later.
//
// Output handshake: rx_valid=1 means rx_data/rx_parity_err/rx_frame_err hold
// an unconsumed word; the word is consumed on any clk edge where rx_valid=1
// and rx_ack=1. rx_ack while rx_valid=0 is ignored. A frame completing while
// a word is still unconsumed (and not acked that cycle) is dropped and
// reported with a one-clk rx_overrun pulse.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic                 rx_pin,
  input  logic                 parity_enable,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 rx_busy
);

  localparam int CW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

`ifdef UART_RX_MAJORITY_VOTE_EN
  // The vote needs the tick after the nominal one, so every decision point
  // moves one tick later; the bit-to-bit spacing stays OVERSAMPLE ticks.
  localparam int START_SAMPLE_I = OVERSAMPLE / 2;
`else
  localparam int START_SAMPLE_I = OVERSAMPLE / 2 - 1;
`endif

  localparam logic [CW-1:0] START_SAMPLE = CW'(START_SAMPLE_I);
  localparam logic [CW-1:0] CNT_LAST     = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST     = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [1:0]             sync_q;
  logic                   rx_s;
  logic                   bit_val;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_en_q, par_en_d;
  logic                   perr_q, perr_d;
  logic                   armed_q, armed_d;
  logic                   commit;

  logic [DATA_BITS-1:0]   data_q;
  logic                   valid_q;
  logic                   out_perr_q;
  logic                   out_ferr_q;
  logic                   overrun_q;

  // Two-flop synchronizer for the asynchronous serial line; idles high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], rx_pin};
  end

  assign rx_s = sync_q[1];

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] hist_q;

  // History of rx_s on the two previous ticks for the 2-of-3 vote.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            hist_q <= 2'b11;
    else if (sample_tick) hist_q <= {hist_q[0], rx_s};
  end

  assign bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
  assign bit_val = rx_s;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and datapath next values; everything advances only on a tick.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    perr_d    = perr_q;
    armed_d   = armed_q;
    commit    = 1'b0;
    if (sample_tick) begin
      case (state_q)
        S_IDLE: begin
          if (armed_q && !rx_s) begin
            state_d  = S_START;
            cnt_d    = '0;
            par_en_d = parity_enable;
            perr_d   = 1'b0;
          end else if (rx_s) begin
            armed_d = 1'b1;
          end
        end
        S_START: begin
          if (cnt_q == START_SAMPLE) begin
            cnt_d = '0;
            if (!bit_val) begin
              state_d   = S_DATA;
              bit_idx_d = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
            if (bit_idx_q == BIT_LAST) begin
              state_d = par_en_q ? S_PARITY : S_STOP;
            end else begin
              bit_idx_d = bit_idx_q + BW'(1);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_PARITY: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            perr_d  = ~((^shift_q) ^ bit_val);
            state_d = S_STOP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            commit  = 1'b1;
            armed_d = 1'b0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath registers of the receive engine.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      perr_q    <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      perr_q    <= perr_d;
      armed_q   <= armed_d;
    end
  end

  // Output word register: commit/drop a finished frame, consume on ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q     <= '0;
      valid_q    <= 1'b0;
      out_perr_q <= 1'b0;
      out_ferr_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (commit) begin
        if (!valid_q || rx_ack) begin
          data_q     <= shift_q;
          out_perr_q <= perr_q;
          out_ferr_q <= ~bit_val;
          valid_q    <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (rx_ack && valid_q) begin
        valid_q    <= 1'b0;
        out_perr_q <= 1'b0;
        out_ferr_q <= 1'b0;
      end
    end
  end

  // Outputs decoded from state and the output word register.
  always_comb begin
    rx_busy       = (state_q != S_IDLE);
    rx_data       = data_q;
    rx_valid      = valid_q;
    rx_parity_err = out_perr_q;
    rx_frame_err  = out_ferr_q;
    rx_overrun    = overrun_q;
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven frames plus hand-written corner sequences for uart_rx.
module tb_uart_rx;

  localparam int DATA_BITS = 8;
  localparam int OS        = 16;

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int              COMMIT_EDGE = 156;
  localparam logic [7:0]      EXP_GLITCH  = 8'hF0;
`else
  localparam int              COMMIT_EDGE = 155;
  localparam logic [7:0]      EXP_GLITCH  = 8'h0F;
`endif

  logic                 clk;
  logic                 reset;
  logic                 sample_tick;
  logic                 rx_pin;
  logic                 parity_enable;
  logic                 rx_ack;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_parity_err;
  logic                 rx_frame_err;
  logic                 rx_overrun;
  logic                 rx_busy;

  int checks = 0;
  int errors = 0;
  int ovr_hi = 0;

  logic [9:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    bit         pe;
    bit         pb;
    bit         sb;
    bit         glitch;
    logic [7:0] exp_data;
    bit         exp_perr;
    bit         exp_ferr;
  } vec_t;

  vec_t vecs[12];

  uart_rx #(.DATA_BITS(DATA_BITS), .OVERSAMPLE(OS)) dut (
    .clk           (clk),
    .reset         (reset),
    .sample_tick   (sample_tick),
    .rx_pin        (rx_pin),
    .parity_enable (parity_enable),
    .rx_ack        (rx_ack),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_parity_err (rx_parity_err),
    .rx_frame_err  (rx_frame_err),
    .rx_overrun    (rx_overrun),
    .rx_busy       (rx_busy)
  );

  // Clock and overrun pulse-width monitor.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (rx_overrun) ovr_hi++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic v, input bit gl);
    for (int c = 0; c < OS; c++) begin
      @(posedge clk);
      #1 rx_pin = (gl && c == OS / 2) ? ~v : v;
    end
  endtask

  // One frame; the line is left at the stop-bit value afterwards.
  task automatic send_frame(input logic [7:0] d, input bit pe, input bit pb,
                            input bit sb, input bit gl);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < DATA_BITS; i++) drive_bit(d[i], gl);
    if (pe) drive_bit(pb, 1'b0);
    drive_bit(sb, 1'b0);
  endtask

  task automatic line_idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1 rx_pin = 1'b1;
    end
  endtask

  task automatic pulse_ack();
    @(posedge clk);
    #1 rx_ack = 1'b1;
    @(posedge clk);
    #1 rx_ack = 1'b0;
  endtask

  // Wait for a word, compare it with the scoreboard head, optionally consume it.
  task automatic expect_word(input string name, input bit do_ack);
    int         waited;
    logic [9:0] exp;
    waited = 0;
    @(negedge clk);
    while (!rx_valid && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    check({name, " valid"}, {31'd0, rx_valid}, 32'd1);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got 0x%0h", name, rx_data);
    end else begin
      exp = exp_q.pop_front();
      check({name, " word"}, {22'd0, rx_data, rx_parity_err, rx_frame_err}, {22'd0, exp});
    end
    if (do_ack) begin
      pulse_ack();
      @(negedge clk);
      check({name, " ack clears"}, {29'd0, rx_valid, rx_parity_err, rx_frame_err}, 32'd0);
    end
  endtask

  initial begin
    bit busy_seen;
    bit valid_seen;
    int ovr_base;
    vec_t v;

    // Stimulus table; the last three entries are random with modelled parity.
    vecs[0] = '{8'hA5, 0, 0, 1, 0, 8'hA5, 0, 0};
    vecs[1] = '{8'h03, 1, 1, 1, 0, 8'h03, 0, 0};
    vecs[2] = '{8'h03, 1, 0, 1, 0, 8'h03, 1, 0};
    vecs[3] = '{8'h5A, 0, 0, 1, 0, 8'h5A, 0, 0};
    vecs[4] = '{8'hFF, 1, 0, 1, 0, 8'hFF, 1, 0};
    vecs[5] = '{8'h00, 1, 1, 1, 0, 8'h00, 0, 0};
    vecs[6] = '{8'h80, 0, 0, 0, 0, 8'h80, 0, 1};
    vecs[7] = '{8'hF0, 0, 0, 1, 1, EXP_GLITCH, 0, 0};
    vecs[8] = '{8'hC3, 1, 1, 0, 0, 8'hC3, 0, 1};
    for (int i = 9; i < 12; i++) begin
      vecs[i].data     = 8'($urandom_range(0, 255));
      vecs[i].pe       = 1'($urandom_range(0, 1));
      vecs[i].pb       = 1'($urandom_range(0, 1));
      vecs[i].sb       = 1'b1;
      vecs[i].glitch   = 1'b0;
      vecs[i].exp_data = vecs[i].data;
      vecs[i].exp_perr = vecs[i].pe && ((^{vecs[i].data, vecs[i].pb}) == 1'b0);
      vecs[i].exp_ferr = 1'b0;
    end

    // Reset state.
    reset = 1'b1;
    sample_tick = 1'b1;
    rx_pin = 1'b1;
    parity_enable = 1'b0;
    rx_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset outputs", {18'd0, rx_data, rx_valid, rx_parity_err, rx_frame_err,
                            rx_overrun, rx_busy}, 32'd0);
    reset = 1'b0;
    line_idle(20);

    // Glitch on the start bit: busy rises then drops, nothing delivered.
    busy_seen = 1'b0;
    valid_seen = 1'b0;
    @(posedge clk);
    #1 rx_pin = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx_pin = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (rx_busy) busy_seen = 1'b1;
      if (rx_valid) valid_seen = 1'b1;
    end
    check("glitch busy seen", {31'd0, busy_seen}, 32'd1);
    check("glitch busy drop", {31'd0, rx_busy}, 32'd0);
    check("glitch no word", {31'd0, valid_seen}, 32'd0);
    line_idle(10);

    // Table-driven frames.
    for (int i = 0; i < 12; i++) begin
      v = vecs[i];
      exp_q.push_back({v.exp_data, v.exp_perr, v.exp_ferr});
      parity_enable = v.pe;
      send_frame(v.data, v.pe, v.pb, v.sb, v.glitch);
      line_idle(24);
      expect_word($sformatf("vec%0d", i), 1'b1);
    end
    parity_enable = 1'b0;

    // Break: stop bit 0 and line held low; no retrigger until line returns high.
    exp_q.push_back({8'h3C, 1'b0, 1'b1});
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_word("break", 1'b1);
    busy_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (rx_busy || rx_valid) busy_seen = 1'b1;
    end
    check("break no retrigger", {31'd0, busy_seen}, 32'd0);
    line_idle(20);
    exp_q.push_back({8'h11, 1'b0, 1'b0});
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
    line_idle(20);
    expect_word("after break", 1'b1);

    // Overrun: second frame dropped, first word kept, one-clk pulse.
    ovr_base = ovr_hi;
    exp_q.push_back({8'h12, 1'b0, 1'b0});
    send_frame(8'h12, 1'b0, 1'b0, 1'b1, 1'b0);
    line_idle(20);
    send_frame(8'h34, 1'b0, 1'b0, 1'b1, 1'b0);
    line_idle(20);
    check("overrun pulse width", ovr_hi - ovr_base, 32'd1);
    expect_word("overrun kept", 1'b1);

    // Ack in the commit cycle: new word replaces old, rx_valid stays 1.
    ovr_base = ovr_hi;
    exp_q.push_back({8'h56, 1'b0, 1'b0});
    send_frame(8'h56, 1'b0, 1'b0, 1'b1, 1'b0);
    line_idle(20);
    exp_q.push_back({8'h34, 1'b0, 1'b0});
    fork
      send_frame(8'h34, 1'b0, 1'b0, 1'b1, 1'b0);
      begin
        logic [9:0] e;
        repeat (COMMIT_EDGE) @(posedge clk);
        #1 rx_ack = 1'b1;
        @(negedge clk);
        e = exp_q.pop_front();
        check("pre-commit word", {22'd0, rx_data, rx_parity_err, rx_frame_err}, {22'd0, e});
        @(posedge clk);
        #1 rx_ack = 1'b0;
        @(negedge clk);
        check("commit ack valid", {31'd0, rx_valid}, 32'd1);
      end
    join
    line_idle(20);
    check("commit ack no overrun", ovr_hi - ovr_base, 32'd0);
    expect_word("commit ack word", 1'b0);

    // Reset mid-DATA with a word held: everything clears at once.
    @(posedge clk);
    #1 rx_pin = 1'b0;
    repeat (OS) @(posedge clk);
    #1 rx_pin = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("busy mid data", {31'd0, rx_busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async reset outputs", {18'd0, rx_data, rx_valid, rx_parity_err, rx_frame_err,
                                  rx_overrun, rx_busy}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    line_idle(60);
    check("no partial word", {30'd0, rx_valid, rx_busy}, 32'd0);

    // Without sample_tick the receiver must not react to the line.
    sample_tick = 1'b0;
    @(posedge clk);
    #1 rx_pin = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("no tick no start", {31'd0, rx_busy}, 32'd0);
    #1 rx_pin = 1'b1;
    sample_tick = 1'b1;
    line_idle(20);

    // Recovery frame.
    exp_q.push_back({8'h96, 1'b0, 1'b0});
    send_frame(8'h96, 1'b0, 1'b0, 1'b1, 1'b0);
    line_idle(20);
    expect_word("recovery", 1'b1);

    check("scoreboard drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver, the receive-side counterpart of the team's baud-tick-driven UART transmitter.
- Frame format: 1 start bit (0), DATA_BITS data bits LSB first, optional odd parity bit, 1 stop bit (1).
- Runs on a 16x oversampling tick and recovers bit centres from the start-bit falling edge.
- Delivers each byte through a valid/ack register with parity, framing and overrun status.

Parameters:
- DATA_BITS, 8, data bits per frame.
- OVERSAMPLE, 16, sample_tick pulses per bit period; must be even and >= 8.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- sample_tick  input  1  one-clk pulse at OVERSAMPLE x baud rate
- rx_pin  input  1  serial line, idle high, asynchronous to clk
- parity_enable  input  1  expect odd parity bit; latched at start-bit detection
- rx_ack  input  1  consumer accepts rx_data when rx_valid is 1
- rx_data  output  DATA_BITS  received word
- rx_valid  output  1  rx_data holds an unconsumed word
- rx_parity_err  output  1  parity status of the word in rx_data
- rx_frame_err  output  1  stop bit was 0 for the word in rx_data
- rx_overrun  output  1  one-clk pulse: a completed frame was dropped
- rx_busy  output  1  frame reception in progress

Behaviour:
- Reset clock and line: reset is asynchronous, active-high; clock is clk.
- Reset values: rx_data=0, all flags=0, rx_busy=0, state=IDLE. The 2-flop rx_pin synchronizer resets to 1.
- Reset mid-frame aborts immediately. No partial word is delivered.
- Timing: all state, counter and sampling updates happen only on clk edges with sample_tick=1. The output handshake (rx_valid/rx_ack) is evaluated every clk.
- Inputs: rx_pin is used only after 2-flop synchronization (rx_s).
- Counter: sample_cnt has width $clog2(OVERSAMPLE). bit_index has width $clog2(DATA_BITS).
- IDLE:
  - Armed only after rx_s has been seen at 1 on at least one tick since leaving STOP. This prevents retriggering during a break.
  - Armed and rx_s=0 -> START, sample_cnt=0, latch parity_enable, rx_busy=1.
- START:
  - sample_cnt increments each tick.
  - At sample_cnt==OVERSAMPLE/2-1, sample rx_s.
  - rx_s=0 -> DATA, sample_cnt=0, bit_index=0.
  - rx_s=1 -> glitch: IDLE, rx_busy=0, no output change.
- DATA:
  - At sample_cnt==OVERSAMPLE-1, sample rx_s into shift register MSB, shift right, sample_cnt=0.
  - Last bit (bit_index==DATA_BITS-1) -> PARITY if latched parity_enable, else STOP. Otherwise bit_index+1.
- PARITY:
  - Sample at sample_cnt==OVERSAMPLE-1, then -> STOP.
  - perr = NOT(XOR of data bits and parity bit). Odd total ones is good.
  - With parity disabled, perr=0.
- STOP:
  - Sample at sample_cnt==OVERSAMPLE-1 -> IDLE (disarmed), rx_busy=0.
  - ferr = (sample==0).
  - The word is committed on this same clk edge, so outputs are visible the next cycle.
- Commit:
  - If rx_valid=0, or rx_ack=1 in the same cycle: load rx_data, rx_parity_err, rx_frame_err and set rx_valid=1.
  - Otherwise drop the new word, keep the old one, and pulse rx_overrun for 1 clk.
- Handshake:
  - rx_ack with rx_valid=1 and no commit -> rx_valid=0 next cycle; error flags clear with it.
  - rx_ack while rx_valid=0 is ignored.
- Sample point: a frame sampled at start centre gives every later sample at bit centre.

Optional Feature:
- Macro: UART_RX_MAJORITY_VOTE_EN.
- Defined:
  - Each bit value (start, data, parity, stop) is the 2-of-3 majority of rx_s at the nominal sample tick and the ticks immediately before and after.
  - The decision is taken on the following tick. Counter alignment of subsequent bits is unchanged.
  - A single-tick glitch at a bit centre is rejected.
- Undefined: single sample at the nominal tick. No extra registers.

Test Plan:
- Basic frame: OVERSAMPLE=16, sample_tick every clk, parity off, frame 0xA5 (16 ticks/bit) -> rx_valid=1 after stop sample, rx_data=0xA5, both error flags 0. Ack clears rx_valid next cycle.
- Parity: parity_enable=1, data 0x03 with parity bit 1 -> rx_parity_err=0. Same data with parity bit 0 -> rx_parity_err=1, rx_data=0x03.
- Glitch start: rx_pin low for 4 ticks, then high -> rx_busy pulses then drops in START, rx_valid stays 0. Next valid frame 0x5A is received correctly.
- Framing/break: frame 0x3C with stop bit 0, line held low 40 ticks -> rx_frame_err=1, rx_data=0x3C. No second frame until line high, then frame 0x11 is received.
- Overrun and reset: two frames 0x12 then 0x34 with no ack -> rx_overrun 1-clk pulse, rx_data=0x12.
  - Ack in the commit cycle of 0x34 -> rx_data=0x34, rx_valid stays 1.
  - Reset asserted mid-DATA -> all outputs 0 immediately.
- With UART_RX_MAJORITY_VOTE_EN: 1-tick inverted glitch at each data-bit centre of 0xF0 -> rx_data=0xF0. Without the macro -> rx_data=0x0F.
